// File: rtl/tp_mem_pkg.sv
// Shared types and sizes for the two-port memory read streamer.
package tp_mem_pkg;

  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned DW        = 16;
  localparam int unsigned LW        = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/tp_mem_rd_fifo2.sv
// Two-entry register FIFO holding {last, data}; head entry drives the stream directly.
module tp_mem_rd_fifo2
  import tp_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        valid,
  output logic [1:0]  count
);

  fifo_entry_t ent0_q, ent0_d;
  fifo_entry_t ent1_q, ent1_d;
  logic [1:0]  count_q, count_d;
  logic        valid_q, valid_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d  = push_entry;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          ent1_d  = push_entry;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = push_entry;
        end else begin
          ent0_d  = push_entry;
          count_d = 2'd1;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head  = ent0_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/tp_mem_rd_streamer.sv
// Burst read sequencer: issues single-cycle memory reads under credit control and
// streams the returned words out on valid/ready with a last marker.
module tp_mem_rd_streamer
  import tp_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] issue_cnt_q, issue_cnt_d;
  logic [LW-1:0] deliver_cnt_q, deliver_cnt_d;
  logic          inflight_q, inflight_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          pop_c;
  logic          issue_c;
  logic [2:0]    occ_c;
  logic [1:0]    fifo_count;
  fifo_entry_t   push_entry_c;
  fifo_entry_t   head;

  // Next-state, issue decision and counter updates.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    issue_c       = 1'b0;
    done_d        = 1'b0;

    pop_c = out_valid & out_ready;
    // Buffered words plus the read in flight, net of the word leaving this cycle.
    occ_c = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);

    push_entry_c.data = mem_rd_word;
    push_entry_c.last = (deliver_cnt_q == LW'(1));
    if (inflight_q) begin
      deliver_cnt_d = deliver_cnt_q - LW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d       = RUN;
          addr_d        = base_addr;
          issue_cnt_d   = len;
          deliver_cnt_d = len;
        end
      end
      RUN: begin
        if ((issue_cnt_q != '0) && (occ_c < 3'd2)) begin
          issue_c     = 1'b1;
          addr_d      = addr_q + AW'(1);
          issue_cnt_d = issue_cnt_q - LW'(1);
          if (issue_cnt_q == LW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_c && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inflight_d = issue_c;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      inflight_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      inflight_q    <= inflight_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  tp_mem_rd_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_q),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .head       (head),
    .valid      (out_valid),
    .count      (fifo_count)
  );

  // Read enable depends on this cycle's pop, so it cannot be registered.
  assign mem_rd_en   = issue_c;
  assign mem_rd_addr = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_data    = head.data;
  assign out_last    = head.last;

endmodule

// File: tb/tb_tp_mem_rd_streamer.sv
// Scoreboard bench for tp_mem_rd_streamer with a behavioural 512x16 memory (word = 0xA000 | addr).
module tb_tp_mem_rd_streamer;
  import tp_mem_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_word;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [MEM_DEPTH];
  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_word [$];

  int          issued;
  int          popped;
  int          mon_occ;
  logic        mon_pop;
  logic        hold_q;
  logic [DW:0] hold_word;

  tp_mem_rd_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_word (mem_rd_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 16'hA000 | DW'(i);
  end

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_word <= mem[mem_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read addresses, delivered words, credit rule, hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      issued = 0;
      popped = 0;
      hold_q = 1'b0;
    end else begin
      mon_occ = issued - popped;
      mon_pop = out_valid && out_ready;
      check("occupancy_le2", 32'(mon_occ <= 2), 32'd1);
      if (hold_q) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_word", 32'({out_last, out_data}), 32'(hold_word));
      end
      if (mem_rd_en) begin
        check("credit", 32'((mon_occ - int'(mon_pop)) < 2), 32'd1);
        if (exp_addr.size() == 0) check("rd_extra", 32'd0, 32'd1);
        else check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr.pop_front()));
      end
      if (mon_pop) begin
        if (exp_word.size() == 0) check("word_extra", 32'd0, 32'd1);
        else check("word", 32'({out_last, out_data}), 32'(exp_word.pop_front()));
      end
      hold_q    = out_valid && !out_ready;
      hold_word = {out_last, out_data};
      issued    = issued + int'(mem_rd_en);
      popped    = popped + int'(mon_pop);
    end
  end

  task automatic expect_burst(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_word.push_back({(i == n - 1), 16'hA000 | DW'(a)});
    end
  endtask

  // Call away from a clock edge; returns 1 time unit into cycle 1 of the burst.
  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] n);
    start     = 1'b1;
    base_addr = b;
    len       = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int k);
    k = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (done && (k == 0)) begin
        k = c;
        break;
      end
    end
    if (k == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_check(input string name);
    check({name, "_rd_left"}, 32'(exp_addr.size()), 32'd0);
    check({name, "_word_left"}, 32'(exp_word.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_rden"}, 32'(mem_rd_en), 32'd0);
    check({name, "_addr"}, 32'(mem_rd_addr), 32'd0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_data"}, 32'(out_data), 32'd0);
    check({name, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst: per-cycle timing table with out_ready held high.
    expect_burst(9'h010, 4);
    do_start(9'h010, 10'd4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("basic_valid", 32'(out_valid), 32'(c >= 3 && c <= 6));
      check("basic_last", 32'(out_valid && out_last), 32'(c == 6));
      check("basic_done", 32'(done), 32'(c == 7));
      check("basic_busy", 32'(busy), 32'(c <= 6));
      check("basic_rden", 32'(mem_rd_en), 32'(c <= 4));
    end
    end_check("basic");

    // Wrap-around across address 511 -> 0.
    @(negedge clk);
    expect_burst(9'h1FE, 4);
    do_start(9'h1FE, 10'd4);
    wait_done(20, k);
    check("wrap_done_cycle", 32'(k), 32'd7);
    end_check("wrap");

    // Start issued in the done cycle, then back-pressure with two 10-cycle stalls.
    expect_burst(9'h020, 8);
    do_start(9'h020, 10'd8);
    check("b2b_busy", 32'(busy), 32'd1);
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = (c < 10 || (c >= 25 && c < 35)) ? 1'b0 : 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      begin
        int kb;
        wait_done(300, kb);
      end
    join
    end_check("bp");

    // Zero-length start is ignored.
    @(negedge clk);
    do_start(9'h055, 10'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_done", 32'(done), 32'd0);
      check("zero_rden", 32'(mem_rd_en), 32'd0);
    end

    // Start pulse during an active burst is ignored.
    expect_burst(9'h080, 3);
    do_start(9'h080, 10'd3);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 9'h1A0;
    len       = 10'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20, k);
    check("mid_done_cycle", 32'(k), 32'd4);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("mid_idle_busy", 32'(busy), 32'd0);
    end
    end_check("mid");

    // Full-length burst from 0x100 covering every address once.
    @(negedge clk);
    expect_burst(9'h100, 512);
    do_start(9'h100, 10'd512);
    wait_done(600, k);
    check("full_done_cycle", 32'(k), 32'd515);
    end_check("full");

    // Reset asserted during cycle 4 of a 16-word burst.
    @(negedge clk);
    expect_burst(9'h040, 16);
    do_start(9'h040, 10'd16);
    repeat (3) @(posedge clk);
    #1 check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    exp_addr.delete();
    exp_word.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_burst(9'h1F0, 2);
    do_start(9'h1F0, 10'd2);
    wait_done(20, k);
    check("post_rst_done_cycle", 32'(k), 32'd5);
    end_check("post_rst");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tp_mem_rd_streamer.md
# tp_mem_rd_streamer

Read-side sequencer placed directly downstream of the 512x16 two-port weight/scratch memory in the MVU user-memory path. When started, it issues a burst of single-cycle reads from a base address, absorbs the memory's one-cycle read latency, and delivers the words on a valid/ready stream with a last marker. A 2-entry output buffer and credit accounting ensure back-pressure never drops or duplicates a word.

## Interface
- AW, 9, memory address width (512 words)
- DW, 16, memory word width
- LW, 10, burst length width (1..512)
- clk  in  1  single clock for all logic and the memory read port
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle burst request; sampled only in IDLE
- base_addr  in  AW  first word address, sampled with start
- len  in  LW  number of words, sampled with start; legal range 1..512
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the burst completes
- mem_rd_en  out  1  read enable to memory, active high
- mem_rd_addr  out  AW  read address to memory
- mem_rd_word  in  DW  read data, valid on the cycle after mem_rd_en
- out_valid  out  1  stream word available
- out_ready  in  1  consumer accepts word
- out_data  out  DW  stream word
- out_last  out  1  marks the final word of the burst; qualified by out_valid

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start with len != 0. Latch addr = base_addr, issue count = len, and deliver count = len. start with len = 0 is ignored: no busy, no done.
- start while busy is ignored.
- RUN issues a read (mem_rd_en = 1, mem_rd_addr = addr) when issue count > 0 and fifo_count + inflight − pop < 2. Here pop = out_valid & out_ready, and inflight is the registered mem_rd_en from the previous cycle.
- Each issued read increments addr modulo 512 (wrap 511 -> 0) and decrements issue count.
- RUN -> DRAIN when the final read issues.
- When inflight = 1, mem_rd_word is pushed into the 2-entry FIFO. The credit rule guarantees the FIFO never overflows.
- out_last is stored per FIFO entry and set on the entry whose deliver count = 1 at push.
- DRAIN -> IDLE on the handshake of the out_last word. done pulses on the following cycle; busy falls in that same cycle.
- mem_rd_en is never asserted in IDLE or DRAIN.
- Reset, including mid-burst, returns to IDLE and clears the FIFO, counters and inflight. An in-flight read is discarded.
- Reset values: busy 0, done 0, mem_rd_en 0, mem_rd_addr 0, out_valid 0, out_data 0, out_last 0.

## Timing
- start accepted at edge 0:
  - busy = 1 in cycle 1.
  - First mem_rd_en in cycle 1.
  - Data pushed at the end of cycle 2.
  - out_valid = 1 in cycle 3.
- With out_ready held high: one word per cycle; an N-word burst's last handshake is in cycle N+2, done in cycle N+3.
- With out_ready low: at most 2 words are buffered, and issue stalls within one cycle. out_data and out_last stay stable while out_valid & !out_ready.
- Simultaneous push and pop with the FIFO full is legal; count stays 2.
- A new start is accepted in the cycle done is high (state is IDLE).

## Structure
- Shared package tp_mem_pkg holds:
  - AW, DW, LW
  - MEM_DEPTH = 512
  - State enum {IDLE, RUN, DRAIN}
- One sub-module: tp_mem_rd_fifo2, a 2-entry register FIFO of {last, data} with push/pop/count. It uses no memory macro.

## Test plan
- **Basic burst:** reset, start with base = 0x010, len = 4, out_ready = 1.
  - Reads hit addresses 0x010..0x013.
  - out_valid is in cycles 3..6, with out_last in cycle 6.
  - done pulses in cycle 7.
- **Wrap-around:** base = 0x1FE, len = 4.
  - mem_rd_addr sequence is 0x1FE, 0x1FF, 0x000, 0x001.
  - Data order is preserved.
- **Back-pressure:** len = 8 with out_ready toggling randomly, including 10-cycle stalls.
  - All 8 words are delivered in order, without loss or duplication.
  - FIFO count never exceeds 2.
  - mem_rd_en is low while the buffer plus in-flight read equals 2.
- **Ignored starts:** start with len = 0 produces no busy and no done. A start pulse mid-burst with different parameters leaves the active burst unaffected.
- **Full-length burst:** len = 512 from base 0x100 covers every address exactly once and delivers 512 words in 514 cycles with out_ready = 1.
- **Reset mid-burst:** assert rst_n low during cycle 4 of a len = 16 burst.
  - All outputs go to 0 immediately.
  - After release, a fresh len = 2 burst works correctly.
